// File: rtl/matrix_slot_scanner_pkg.sv
// Shared types and header-field layout for the matrix-storage slot scanner.
package matrix_scan_pkg;

    // Shape filter applied to every usable slot header.
    typedef enum logic [1:0] {
        FILT_ANY   = 2'd0,
        FILT_EXACT = 2'd1,
        FILT_ROWS  = 2'd2,
        FILT_COLS  = 2'd3
    } scan_filter_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_CHECK = 3'd3,
        ST_EMIT  = 3'd4,
        ST_NEXT  = 3'd5,
        ST_DONE  = 3'd6
    } scan_state_t;

    // Header word layout (bits [31:0] of the first word of every slot).
    localparam int HDR_ID_MSB    = 31;
    localparam int HDR_ID_LSB    = 24;
    localparam int HDR_ROWS_MSB  = 23;
    localparam int HDR_ROWS_LSB  = 16;
    localparam int HDR_COLS_MSB  = 15;
    localparam int HDR_COLS_LSB  = 8;
    localparam int HDR_VALID_BIT = 0;

    // True when a usable slot's shape satisfies the requested filter.
    function automatic logic filter_pass(input scan_filter_t filt,
                                         input logic [7:0]   rows,
                                         input logic [7:0]   cols,
                                         input logic [7:0]   want_rows,
                                         input logic [7:0]   want_cols);
        logic pass;
        pass = 1'b0;
        case (filt)
            FILT_ANY:   pass = 1'b1;
            FILT_EXACT: pass = (rows == want_rows) && (cols == want_cols);
            FILT_ROWS:  pass = (rows == want_rows);
            FILT_COLS:  pass = (cols == want_cols);
            default:    pass = 1'b0;
        endcase
        return pass;
    endfunction

endpackage

// File: rtl/matrix_slot_scanner_header_decode.sv
// Combinational slot-header decoder: splits the header word into fields,
// decides whether the slot holds a usable matrix, and applies the shape filter.
module matrix_header_decode
    import matrix_scan_pkg::*;
(
    input  logic [31:0]  hdr_word,
    input  logic [7:0]   slot_idx,
    input  scan_filter_t filter,
    input  logic [7:0]   want_rows,
    input  logic [7:0]   want_cols,
    output logic [7:0]   hdr_id,
    output logic [7:0]   hdr_rows,
    output logic [7:0]   hdr_cols,
    output logic         usable,
    output logic         hit,
    output logic         id_mismatch
);

    logic hdr_valid;
    logic unused_hdr_bits;

    // Reserved header bits carry no meaning for the scan.
    assign unused_hdr_bits = ^hdr_word[HDR_COLS_LSB-1:HDR_VALID_BIT+1];

    // Field split, usability test and filter match.
    always_comb begin
        hdr_id      = hdr_word[HDR_ID_MSB:HDR_ID_LSB];
        hdr_rows    = hdr_word[HDR_ROWS_MSB:HDR_ROWS_LSB];
        hdr_cols    = hdr_word[HDR_COLS_MSB:HDR_COLS_LSB];
        hdr_valid   = hdr_word[HDR_VALID_BIT];
        id_mismatch = hdr_valid && (hdr_id != slot_idx);
        usable      = hdr_valid && (hdr_id == slot_idx) &&
                      (hdr_rows != 8'd0) && (hdr_cols != 8'd0);
        hit         = usable &&
                      filter_pass(filter, hdr_rows, hdr_cols, want_rows, want_cols);
    end

endmodule

// File: rtl/matrix_slot_scanner.sv
// Matrix slot scanner: walks slot headers in BRAM, filters them by shape and
// streams every hit over a valid/ready port, keeping a hit mask and count.
module matrix_slot_scanner
    import matrix_scan_pkg::*;
#(
    parameter int BLOCK_SIZE   = 1152,
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 14,
    parameter int NUM_SLOTS    = 8,
    parameter int FIRST_SLOT   = 1,
    parameter int READ_LATENCY = 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic                             abort,
    input  logic [1:0]                       filter_mode,
    input  logic [7:0]                       want_rows,
    input  logic [7:0]                       want_cols,
    output logic [ADDR_WIDTH-1:0]            bram_rd_addr,
    input  logic [DATA_WIDTH-1:0]            bram_rd_data,
    output logic                             match_valid,
    input  logic                             match_ready,
    output logic [7:0]                       match_id,
    output logic [7:0]                       match_rows,
    output logic [7:0]                       match_cols,
    output logic [NUM_SLOTS-1:0]             match_mask,
    output logic [$clog2(NUM_SLOTS+1)-1:0]   match_count,
    output logic                             busy,
    output logic                             done,
    output logic                             hdr_error
);

    localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int CNT_W  = $clog2(NUM_SLOTS + 1);
    localparam int LAT_W  = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    localparam logic [ADDR_WIDTH-1:0] FIRST_ADDR = ADDR_WIDTH'(FIRST_SLOT * BLOCK_SIZE);
    localparam logic [ADDR_WIDTH-1:0] BLOCK_STEP = ADDR_WIDTH'(BLOCK_SIZE);
    localparam logic [SLOT_W-1:0]     FIRST_IDX  = SLOT_W'(FIRST_SLOT);
    localparam logic [SLOT_W-1:0]     LAST_SLOT  = SLOT_W'(NUM_SLOTS - 1);
    localparam logic [LAT_W-1:0]      LAT_LAST   = LAT_W'(READ_LATENCY - 1);
    localparam bit                    EMPTY_SCAN = (FIRST_SLOT >= NUM_SLOTS);

    scan_state_t             state;
    scan_state_t             next_state;
    logic [SLOT_W-1:0]       slot;
    logic [ADDR_WIDTH-1:0]   addr_acc;
    logic [LAT_W-1:0]        lat_cnt;
    scan_filter_t            filt_q;
    logic [7:0]              want_rows_q;
    logic [7:0]              want_cols_q;
    logic                    scan_start;

    logic [7:0]              dec_id;
    logic [7:0]              dec_rows;
    logic [7:0]              dec_cols;
    logic                    dec_usable;
    logic                    dec_hit;
    logic                    dec_id_mismatch;
    logic                    unused_dec;

    assign scan_start = (state == ST_IDLE) && start && !abort;
    assign unused_dec = dec_usable;

    matrix_header_decode u_decode (
        .hdr_word    (bram_rd_data[31:0]),
        .slot_idx    (8'(slot)),
        .filter      (filt_q),
        .want_rows   (want_rows_q),
        .want_cols   (want_cols_q),
        .hdr_id      (dec_id),
        .hdr_rows    (dec_rows),
        .hdr_cols    (dec_cols),
        .usable      (dec_usable),
        .hit         (dec_hit),
        .id_mismatch (dec_id_mismatch)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and state-decoded outputs; abort overrides every transition.
    always_comb begin
        next_state  = state;
        match_valid = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start && !abort) begin
                    next_state = EMPTY_SCAN ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                busy       = 1'b1;
                next_state = ST_WAIT;
            end
            ST_WAIT: begin
                busy = 1'b1;
                if (lat_cnt == LAT_LAST) begin
                    next_state = ST_CHECK;
                end
            end
            ST_CHECK: begin
                busy       = 1'b1;
                next_state = dec_hit ? ST_EMIT : ST_NEXT;
            end
            ST_EMIT: begin
                busy        = 1'b1;
                match_valid = 1'b1;
                if (match_ready) begin
                    next_state = ST_NEXT;
                end
            end
            ST_NEXT: begin
                busy       = 1'b1;
                next_state = (slot == LAST_SLOT) ? ST_DONE : ST_ISSUE;
            end
            ST_DONE: begin
                done       = 1'b1;
                next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
        if (abort && (state != ST_IDLE)) begin
            next_state = ST_IDLE;
        end
    end

    // Scan request latch: filter and wanted shape are captured when a scan is accepted.
    always_ff @(posedge clk) begin
        if (scan_start) begin
            filt_q      <= scan_filter_t'(filter_mode);
            want_rows_q <= want_rows;
            want_cols_q <= want_cols;
        end
    end

    // Scan datapath: slot/address walk, read-latency count, hit bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot         <= '0;
            addr_acc     <= '0;
            lat_cnt      <= '0;
            bram_rd_addr <= '0;
            match_id     <= '0;
            match_rows   <= '0;
            match_cols   <= '0;
            match_mask   <= '0;
            match_count  <= '0;
            hdr_error    <= 1'b0;
        end else if (scan_start) begin
            slot        <= FIRST_IDX;
            addr_acc    <= FIRST_ADDR;
            match_mask  <= '0;
            match_count <= '0;
            hdr_error   <= 1'b0;
        end else if (!abort) begin
            case (state)
                ST_ISSUE: begin
                    bram_rd_addr <= addr_acc;
                    lat_cnt      <= '0;
                end
                ST_WAIT: begin
                    if (lat_cnt != LAT_LAST) begin
                        lat_cnt <= lat_cnt + LAT_W'(1);
                    end
                end
                ST_CHECK: begin
                    if (dec_id_mismatch) begin
                        hdr_error <= 1'b1;
                    end
                    if (dec_hit) begin
                        match_mask  <= match_mask | (NUM_SLOTS'(1) << slot);
                        match_count <= match_count + CNT_W'(1);
                        match_id    <= dec_id;
                        match_rows  <= dec_rows;
                        match_cols  <= dec_cols;
                    end
                end
                ST_NEXT: begin
                    if (slot != LAST_SLOT) begin
                        slot     <= slot + SLOT_W'(1);
                        addr_acc <= addr_acc + BLOCK_STEP;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_slot_scanner.sv
// Directed bench for matrix_slot_scanner: one instance with single-cycle BRAM
// reads for the functional scenarios, one with two-cycle reads for the ANY scan.
module tb_matrix_slot_scanner;
    import matrix_scan_pkg::*;

    localparam int BS = 1152;
    localparam int AW = 14;
    localparam int NS = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Instance 1 (READ_LATENCY = 1)
    logic        start = 1'b0, abort = 1'b0, match_ready = 1'b0;
    logic [1:0]  filter_mode = 2'd0;
    logic [7:0]  want_rows = 8'd0, want_cols = 8'd0;
    logic [AW-1:0] rd_addr;
    logic [31:0] rd_data = 32'd0;
    logic        match_valid, busy, done, hdr_error;
    logic [7:0]  match_id, match_rows, match_cols, match_mask;
    logic [3:0]  match_count;

    // Instance 2 (READ_LATENCY = 2)
    logic        start2 = 1'b0, abort2 = 1'b0, ready2 = 1'b1;
    logic [1:0]  filter_mode2 = 2'd0;
    logic [7:0]  want_rows2 = 8'd0, want_cols2 = 8'd0;
    logic [AW-1:0] rd_addr2;
    logic [31:0] rd_data2 = 32'd0, rd2_p = 32'd0;
    logic        valid2, busy2, done2, hdr_error2;
    logic [7:0]  id2, rows2, cols2, mask2;
    logic [3:0]  count2;

    logic [31:0] hdr [0:NS-1];
    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    matrix_slot_scanner #(.READ_LATENCY(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .filter_mode(filter_mode), .want_rows(want_rows), .want_cols(want_cols),
        .bram_rd_addr(rd_addr), .bram_rd_data(rd_data),
        .match_valid(match_valid), .match_ready(match_ready),
        .match_id(match_id), .match_rows(match_rows), .match_cols(match_cols),
        .match_mask(match_mask), .match_count(match_count),
        .busy(busy), .done(done), .hdr_error(hdr_error)
    );

    matrix_slot_scanner #(.READ_LATENCY(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2),
        .filter_mode(filter_mode2), .want_rows(want_rows2), .want_cols(want_cols2),
        .bram_rd_addr(rd_addr2), .bram_rd_data(rd_data2),
        .match_valid(valid2), .match_ready(ready2),
        .match_id(id2), .match_rows(rows2), .match_cols(cols2),
        .match_mask(mask2), .match_count(count2),
        .busy(busy2), .done(done2), .hdr_error(hdr_error2)
    );

    // Header words live at slot*BS; any other address returns a poison word
    // whose VALID bit is set and whose ID mismatches, so a bad address shows up.
    function automatic logic [31:0] hdr_at(input logic [AW-1:0] a);
        int ai;
        ai = int'(a);
        if ((ai % BS) == 0 && (ai / BS) < NS) return hdr[ai / BS];
        return 32'hDEAD_BE01;
    endfunction

    always @(posedge clk) rd_data <= hdr_at(rd_addr);

    always @(posedge clk) begin
        rd2_p    <= hdr_at(rd_addr2);
        rd_data2 <= rd2_p;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic kick(input scan_filter_t f, input logic [7:0] r, input logic [7:0] c);
        filter_mode = f;
        want_rows   = r;
        want_cols   = c;
        start       = 1'b1;
        @(negedge clk);
        start       = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int k;
        k = 0;
        while (!match_valid && k < 200) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_valid"}, match_valid, 1);
    endtask

    task automatic expect_hit(input string tag, input logic [7:0] id,
                              input logic [7:0] r, input logic [7:0] c);
        wait_valid(tag);
        check({tag, "_id"}, match_id, id);
        check({tag, "_rows"}, match_rows, r);
        check({tag, "_cols"}, match_cols, c);
        check({tag, "_addr"}, rd_addr, id * BS);
    endtask

    task automatic accept();
        match_ready = 1'b1;
        @(negedge clk);
        match_ready = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int k;
        int stray;
        k = 0;
        stray = 0;
        while (!done && k < 300) begin
            if (match_valid) stray++;
            @(negedge clk);
            k++;
        end
        check({tag, "_done"}, done, 1);
        check({tag, "_no_extra_hit"}, stray, 0);
    endtask

    task automatic expect_pulse_end(input string tag);
        @(negedge clk);
        check({tag, "_done_pulse"}, done, 0);
        check({tag, "_idle_busy"}, busy, 0);
    endtask

    initial begin
        for (int i = 0; i < NS; i++) hdr[i] = 32'd0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid", match_valid, 0);
        check("rst_mask", match_mask, 0);
        check("rst_count", match_count, 0);
        check("rst_hdr_err", hdr_error, 0);
        check("rst_addr", rd_addr, 0);
        check("rst_id", match_id, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: single exact hit on slot 1
        hdr[1] = 32'h0102_0201;
        kick(FILT_EXACT, 8'd2, 8'd2);
        check("t1_busy", busy, 1);
        expect_hit("t1", 8'd1, 8'd2, 8'd2);
        accept();
        check("t1_valid_drop", match_valid, 0);
        wait_done("t1");
        check("t1_mask", match_mask, 8'h02);
        check("t1_count", match_count, 1);
        check("t1_hdr_err", hdr_error, 0);
        expect_pulse_end("t1");
        check("t1_mask_hold", match_mask, 8'h02);

        // 2: rows filter, two hits in slot order
        hdr[2] = 32'h0202_0301;
        hdr[3] = 32'h0303_0201;
        kick(FILT_ROWS, 8'd2, 8'd0);
        expect_hit("t2a", 8'd1, 8'd2, 8'd2);
        accept();
        expect_hit("t2b", 8'd2, 8'd2, 8'd3);
        accept();
        wait_done("t2");
        check("t2_mask", match_mask, 8'h06);
        check("t2_count", match_count, 2);
        expect_pulse_end("t2");

        // 3: cols filter with back-pressure; hit must hold steady
        kick(FILT_COLS, 8'd0, 8'd2);
        expect_hit("t3a", 8'd1, 8'd2, 8'd2);
        begin
            int stable;
            stable = 1;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (!(match_valid && match_id == 8'd1 && match_rows == 8'd2 &&
                      match_cols == 8'd2 && busy)) stable = 0;
            end
            check("t3_hold_stable", stable, 1);
        end
        accept();
        expect_hit("t3b", 8'd3, 8'd3, 8'd2);
        accept();
        wait_done("t3");
        check("t3_mask", match_mask, 8'h0A);
        check("t3_count", match_count, 2);
        expect_pulse_end("t3");

        // 4: slot 4 carries a foreign ID
        hdr[4] = 32'h0702_0201;
        kick(FILT_EXACT, 8'd2, 8'd2);
        expect_hit("t4", 8'd1, 8'd2, 8'd2);
        accept();
        wait_done("t4");
        check("t4_hdr_err", hdr_error, 1);
        check("t4_mask", match_mask, 8'h02);
        check("t4_count", match_count, 1);
        expect_pulse_end("t4");
        check("t4_hdr_err_hold", hdr_error, 1);

        // 5: abort during EMIT on id2, then a clean rescan
        kick(FILT_ROWS, 8'd2, 8'd0);
        check("t5_err_cleared", hdr_error, 0);
        expect_hit("t5a", 8'd1, 8'd2, 8'd2);
        accept();
        expect_hit("t5b", 8'd2, 8'd2, 8'd3);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("t5_abort_busy", busy, 0);
        check("t5_abort_valid", match_valid, 0);
        check("t5_abort_done", done, 0);
        check("t5_abort_mask", match_mask, 8'h06);
        check("t5_abort_count", match_count, 2);
        begin
            int seen_done;
            seen_done = 0;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                if (done || busy) seen_done = 1;
            end
            check("t5_quiet_after_abort", seen_done, 0);
        end
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("t5_start_abort_idle", busy, 0);
        kick(FILT_ROWS, 8'd2, 8'd0);
        check("t5_rescan_mask_clr", match_mask, 8'h00);
        expect_hit("t5c", 8'd1, 8'd2, 8'd2);
        accept();
        expect_hit("t5d", 8'd2, 8'd2, 8'd3);
        accept();
        wait_done("t5");
        check("t5_mask", match_mask, 8'h06);
        check("t5_count", match_count, 2);
        check("t5_hdr_err", hdr_error, 1);
        expect_pulse_end("t5");

        // Asynchronous reset in the middle of a scan
        kick(FILT_ANY, 8'd0, 8'd0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_mask", match_mask, 0);
        check("arst_addr", rd_addr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 6: two-cycle read latency, ANY filter over seven valid slots
        hdr[0] = 32'd0;
        for (int k = 1; k < NS; k++) hdr[k] = {8'(k), 8'(k), 8'(9 - k), 8'h01};
        filter_mode2 = FILT_ANY;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        begin
            int exp_k;
            int k;
            exp_k = 1;
            k = 0;
            while (!done2 && k < 400) begin
                if (valid2) begin
                    check("t6_id", id2, exp_k);
                    check("t6_rows", rows2, exp_k);
                    check("t6_cols", cols2, 9 - exp_k);
                    check("t6_addr", rd_addr2, exp_k * BS);
                    exp_k++;
                end
                @(negedge clk);
                k++;
            end
            check("t6_done", done2, 1);
            check("t6_hits", exp_k, 8);
        end
        check("t6_mask", mask2, 8'hFE);
        check("t6_count", count2, 7);
        check("t6_hdr_err", hdr_error2, 0);
        @(negedge clk);
        check("t6_done_pulse", done2, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
